// File: rtl/gtech_quiet_detect_if.sv
// Bundle of sample inputs and qualified idle outputs for gtech_quiet_detect.
// The master side drives the activity lines; the slave side is the detector.
interface gtech_quiet_detect_if #(
    parameter int CNT_W = 16
);
    logic             EN;
    logic             A;
    logic             B;
    logic             C;
    logic             D;
    logic             IDLE;
    logic             ENTER_P;
    logic             EXIT_P;
    logic             GLITCH_P;
    logic [CNT_W-1:0] QUIET_CNT;
    logic [7:0]       ENTRY_CNT;

    modport master (
        output EN, A, B, C, D,
        input  IDLE, ENTER_P, EXIT_P, GLITCH_P, QUIET_CNT, ENTRY_CNT
    );

    modport slave (
        input  EN, A, B, C, D,
        output IDLE, ENTER_P, EXIT_P, GLITCH_P, QUIET_CNT, ENTRY_CNT
    );
endinterface

// File: rtl/gtech_quiet_detect.sv
// Qualifies the NOR4 all-quiet term into a hysteretic IDLE flag with entry/exit/glitch
// pulses, a saturating quiet-run counter and a saturating idle-entry counter.
module gtech_quiet_detect #(
    parameter int IDLE_CYC = 16,
    parameter int WAKE_CYC = 2,
    parameter int CNT_W    = 16
) (
    input logic                CP,
    input logic                RST,
    gtech_quiet_detect_if.slave bus
);
    localparam int QW = $clog2(IDLE_CYC + 1);
    localparam int AW = $clog2(WAKE_CYC + 1);
    localparam logic [QW-1:0] Q_ONE    = QW'(1);
    localparam logic [QW-1:0] Q_TARGET = QW'(IDLE_CYC);
    localparam logic [AW-1:0] A_ONE    = AW'(1);
    localparam logic [AW-1:0] A_TARGET = AW'(WAKE_CYC);

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_QUIESCE,
        ST_IDLE,
        ST_WAKE
    } state_t;

    state_t           state_q, state_n;
    logic [QW-1:0]    qrun_q, qrun_n;
    logic [AW-1:0]    arun_q, arun_n;
    logic             idle_q, idle_n;
    logic             enter_q, enter_n;
    logic             exit_q, exit_n;
    logic             glitch_q, glitch_n;
    logic [CNT_W-1:0] quiet_cnt_q, quiet_cnt_n;
    logic [7:0]       entry_cnt_q, entry_cnt_n;
    logic             quiet;

    assign quiet = ~(bus.A | bus.B | bus.C | bus.D);

    always_ff @(posedge CP) begin
        if (RST) begin
            state_q     <= ST_ACTIVE;
            qrun_q      <= '0;
            arun_q      <= '0;
            idle_q      <= 1'b0;
            enter_q     <= 1'b0;
            exit_q      <= 1'b0;
            glitch_q    <= 1'b0;
            quiet_cnt_q <= '0;
            entry_cnt_q <= '0;
        end else begin
            state_q     <= state_n;
            qrun_q      <= qrun_n;
            arun_q      <= arun_n;
            idle_q      <= idle_n;
            enter_q     <= enter_n;
            exit_q      <= exit_n;
            glitch_q    <= glitch_n;
            quiet_cnt_q <= quiet_cnt_n;
            entry_cnt_q <= entry_cnt_n;
        end
    end

    // Run counters only count the current run; they are cleared whenever the run ends.
    always_comb begin
        state_n = state_q;
        qrun_n  = qrun_q;
        arun_n  = arun_q;
        if (bus.EN) begin
            unique case (state_q)
                ST_ACTIVE: begin
                    if (quiet) begin
                        if (IDLE_CYC == 1) begin
                            state_n = ST_IDLE;
                            qrun_n  = '0;
                        end else begin
                            state_n = ST_QUIESCE;
                            qrun_n  = Q_ONE;
                        end
                    end
                end
                ST_QUIESCE: begin
                    if (quiet) begin
                        if (qrun_q + Q_ONE == Q_TARGET) begin
                            state_n = ST_IDLE;
                            qrun_n  = '0;
                        end else begin
                            qrun_n  = qrun_q + Q_ONE;
                        end
                    end else begin
                        state_n = ST_ACTIVE;
                        qrun_n  = '0;
                    end
                end
                ST_IDLE: begin
                    if (!quiet) begin
                        if (WAKE_CYC == 1) begin
                            state_n = ST_ACTIVE;
                            arun_n  = '0;
                        end else begin
                            state_n = ST_WAKE;
                            arun_n  = A_ONE;
                        end
                    end
                end
                ST_WAKE: begin
                    if (!quiet) begin
                        if (arun_q + A_ONE == A_TARGET) begin
                            state_n = ST_ACTIVE;
                            arun_n  = '0;
                        end else begin
                            arun_n  = arun_q + A_ONE;
                        end
                    end else begin
                        state_n = ST_IDLE;
                        arun_n  = '0;
                    end
                end
                default: begin
                    state_n = ST_ACTIVE;
                    qrun_n  = '0;
                    arun_n  = '0;
                end
            endcase
        end
    end

    // Pulses are decoded from the transition so they line up with the new IDLE value.
    always_comb begin
        idle_n   = (state_n == ST_IDLE) || (state_n == ST_WAKE);
        enter_n  = bus.EN && ((state_q == ST_ACTIVE) || (state_q == ST_QUIESCE))
                   && (state_n == ST_IDLE);
        exit_n   = bus.EN && ((state_q == ST_IDLE) || (state_q == ST_WAKE))
                   && (state_n == ST_ACTIVE);
        glitch_n = bus.EN && (state_q == ST_WAKE) && (state_n == ST_IDLE);
    end

    always_comb begin
        quiet_cnt_n = quiet_cnt_q;
        entry_cnt_n = entry_cnt_q;
        if (bus.EN) begin
            if (!quiet) begin
                quiet_cnt_n = '0;
            end else if (quiet_cnt_q != {CNT_W{1'b1}}) begin
                quiet_cnt_n = quiet_cnt_q + 1'b1;
            end
        end
        if (enter_n && (entry_cnt_q != 8'hFF)) begin
            entry_cnt_n = entry_cnt_q + 8'd1;
        end
    end

    assign bus.IDLE      = idle_q;
    assign bus.ENTER_P   = enter_q;
    assign bus.EXIT_P    = exit_q;
    assign bus.GLITCH_P  = glitch_q;
    assign bus.QUIET_CNT = quiet_cnt_q;
    assign bus.ENTRY_CNT = entry_cnt_q;
endmodule

// File: tb/tb_gtech_quiet_detect.sv
// Directed bench for gtech_quiet_detect: dut0 uses the default thresholds, dut1 uses
// IDLE_CYC=1/WAKE_CYC=1/CNT_W=4 to reach the saturation limits quickly.
module tb_gtech_quiet_detect;
    logic CP = 1'b0;
    logic RST;
    int   errors = 0;
    int   checks = 0;

    always #5 CP = ~CP;

    gtech_quiet_detect_if #(.CNT_W(16)) bus0 ();
    gtech_quiet_detect_if #(.CNT_W(4))  bus1 ();

    gtech_quiet_detect #(.IDLE_CYC(16), .WAKE_CYC(2), .CNT_W(16)) dut0 (
        .CP(CP), .RST(RST), .bus(bus0.slave)
    );
    gtech_quiet_detect #(.IDLE_CYC(1), .WAKE_CYC(1), .CNT_W(4)) dut1 (
        .CP(CP), .RST(RST), .bus(bus1.slave)
    );

    task automatic tick();
        @(posedge CP);
        #1;
    endtask

    // Flag nibble order everywhere: {IDLE, ENTER_P, EXIT_P, GLITCH_P}.
    task automatic test_reset();
        RST = 1'b1;
        bus0.EN = 1'b1;
        bus1.EN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            {bus0.A, bus0.B, bus0.C, bus0.D} = (i == 0) ? 4'b0101 : 4'b1010;
            {bus1.A, bus1.B, bus1.C, bus1.D} = (i == 0) ? 4'b1010 : 4'b0101;
            tick();
        end
        checks++;
        if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags0: got %b expected 0000",
                     {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P});
        end
        checks++;
        if (bus0.QUIET_CNT !== 16'd0 || bus0.ENTRY_CNT !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnt0: got q=%0d e=%0d expected 0 0", bus0.QUIET_CNT, bus0.ENTRY_CNT);
        end
        checks++;
        if ({bus1.IDLE, bus1.ENTER_P, bus1.EXIT_P, bus1.GLITCH_P, bus1.QUIET_CNT, bus1.ENTRY_CNT} !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_dut1: got %b %0d %0d expected all 0",
                     {bus1.IDLE, bus1.ENTER_P, bus1.EXIT_P, bus1.GLITCH_P}, bus1.QUIET_CNT, bus1.ENTRY_CNT);
        end
        RST = 1'b0;
        bus1.EN = 1'b0;
        {bus1.A, bus1.B, bus1.C, bus1.D} = 4'b0000;
        {bus0.A, bus0.B, bus0.C, bus0.D} = 4'b0000;
    endtask

    task automatic test_entry();
        logic [3:0] exp;
        for (int i = 1; i <= 16; i++) begin
            tick();
            exp = (i == 16) ? 4'b1100 : 4'b0000;
            checks++;
            if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== exp || bus0.QUIET_CNT !== 16'(i)) begin
                errors++;
                $display("[TB] FAIL entry_step%0d: got %b q=%0d expected %b q=%0d", i,
                         {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, bus0.QUIET_CNT, exp, i);
            end
        end
        checks++;
        if (bus0.ENTRY_CNT !== 8'd1) begin
            errors++;
            $display("[TB] FAIL entry_cnt: got %0d expected 1", bus0.ENTRY_CNT);
        end
        tick();
        checks++;
        if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== 4'b1000 || bus0.QUIET_CNT !== 16'd17) begin
            errors++;
            $display("[TB] FAIL entry_hold: got %b q=%0d expected 1000 q=17",
                     {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, bus0.QUIET_CNT);
        end
    endtask

    task automatic test_glitch();
        bus0.C = 1'b1;
        tick();
        checks++;
        if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== 4'b1000 || bus0.QUIET_CNT !== 16'd0) begin
            errors++;
            $display("[TB] FAIL glitch_wake: got %b q=%0d expected 1000 q=0",
                     {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, bus0.QUIET_CNT);
        end
        bus0.C = 1'b0;
        tick();
        checks++;
        if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== 4'b1001 || bus0.ENTRY_CNT !== 8'd1) begin
            errors++;
            $display("[TB] FAIL glitch_pulse: got %b e=%0d expected 1001 e=1",
                     {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, bus0.ENTRY_CNT);
        end
        tick();
        checks++;
        if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL glitch_once: got %b expected 1000",
                     {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P});
        end
    endtask

    task automatic test_wake();
        logic [3:0] exp;
        bus0.D = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            exp = (i == 1) ? 4'b1000 : ((i == 2) ? 4'b0010 : 4'b0000);
            checks++;
            if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== exp) begin
                errors++;
                $display("[TB] FAIL wake_step%0d: got %b expected %b", i,
                         {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, exp);
            end
        end
        bus0.D = 1'b0;
    endtask

    task automatic test_entry_aborted();
        logic [3:0] exp;
        for (int i = 1; i <= 15; i++) tick();
        bus0.B = 1'b1;
        tick();
        bus0.B = 1'b0;
        checks++;
        if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== 4'b0000
            || bus0.QUIET_CNT !== 16'd0 || bus0.ENTRY_CNT !== 8'd1) begin
            errors++;
            $display("[TB] FAIL abort: got %b q=%0d e=%0d expected 0000 q=0 e=1",
                     {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, bus0.QUIET_CNT, bus0.ENTRY_CNT);
        end
        for (int i = 15; i <= 16; i++) begin
            for (int j = (i == 15) ? 1 : 16; j <= i; j++) tick();
            exp = (i == 16) ? 4'b1100 : 4'b0000;
            checks++;
            if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== exp || bus0.QUIET_CNT !== 16'(i)) begin
                errors++;
                $display("[TB] FAIL abort_rerun%0d: got %b q=%0d expected %b q=%0d", i,
                         {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, bus0.QUIET_CNT, exp, i);
            end
        end
        bus0.A = 1'b1;
        tick();
        tick();
        bus0.A = 1'b0;
        checks++;
        if ({bus0.IDLE, bus0.EXIT_P} !== 2'b01 || bus0.ENTRY_CNT !== 8'd2) begin
            errors++;
            $display("[TB] FAIL abort_exit: got idle=%b exit=%b e=%0d expected 0 1 e=2",
                     bus0.IDLE, bus0.EXIT_P, bus0.ENTRY_CNT);
        end
    endtask

    task automatic test_freeze();
        logic [3:0] exp;
        for (int i = 1; i <= 5; i++) tick();
        bus0.EN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus0.A = i[0];
            tick();
            checks++;
            if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== 4'b0000 || bus0.QUIET_CNT !== 16'd5) begin
                errors++;
                $display("[TB] FAIL freeze%0d: got %b q=%0d expected 0000 q=5", i,
                         {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, bus0.QUIET_CNT);
            end
        end
        bus0.A = 1'b0;
        bus0.EN = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i >= 10) begin
                exp = (i == 11) ? 4'b1100 : 4'b0000;
                checks++;
                if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== exp || bus0.QUIET_CNT !== 16'(5 + i)) begin
                    errors++;
                    $display("[TB] FAIL resume%0d: got %b q=%0d expected %b q=%0d", i,
                             {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, bus0.QUIET_CNT, exp, 5 + i);
                end
            end
        end
        bus0.EN = 1'b0;
        tick();
        checks++;
        if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== 4'b1000
            || bus0.QUIET_CNT !== 16'd16 || bus0.ENTRY_CNT !== 8'd3) begin
            errors++;
            $display("[TB] FAIL freeze_pulse: got %b q=%0d e=%0d expected 1000 q=16 e=3",
                     {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, bus0.QUIET_CNT, bus0.ENTRY_CNT);
        end
        bus0.EN = 1'b1;
        bus0.A = 1'b1;
        tick();
        tick();
        bus0.A = 1'b0;
        checks++;
        if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL freeze_exit: got %b expected 0010",
                     {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P});
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 1; i <= 10; i++) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== 4'b0000
            || bus0.QUIET_CNT !== 16'd0 || bus0.ENTRY_CNT !== 8'd0) begin
            errors++;
            $display("[TB] FAIL rst_quiesce: got %b q=%0d e=%0d expected 0000 q=0 e=0",
                     {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, bus0.QUIET_CNT, bus0.ENTRY_CNT);
        end
        for (int i = 1; i <= 15; i++) tick();
        checks++;
        if (bus0.IDLE !== 1'b0 || bus0.QUIET_CNT !== 16'd15) begin
            errors++;
            $display("[TB] FAIL rst_rerun15: got idle=%b q=%0d expected idle=0 q=15", bus0.IDLE, bus0.QUIET_CNT);
        end
        tick();
        checks++;
        if ({bus0.IDLE, bus0.ENTER_P} !== 2'b11 || bus0.ENTRY_CNT !== 8'd1) begin
            errors++;
            $display("[TB] FAIL rst_rerun16: got idle=%b enter=%b e=%0d expected 1 1 e=1",
                     bus0.IDLE, bus0.ENTER_P, bus0.ENTRY_CNT);
        end
        bus0.D = 1'b1;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        bus0.D = 1'b0;
        checks++;
        if ({bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P} !== 4'b0000 || bus0.ENTRY_CNT !== 8'd0) begin
            errors++;
            $display("[TB] FAIL rst_wake: got %b e=%0d expected 0000 e=0",
                     {bus0.IDLE, bus0.ENTER_P, bus0.EXIT_P, bus0.GLITCH_P}, bus0.ENTRY_CNT);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] exp;
        bus0.EN = 1'b0;
        bus1.EN = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            exp = (i == 1) ? 4'b1100 : 4'b1000;
            checks++;
            if ({bus1.IDLE, bus1.ENTER_P, bus1.EXIT_P, bus1.GLITCH_P} !== exp
                || bus1.QUIET_CNT !== 4'((i > 15) ? 15 : i)) begin
                errors++;
                $display("[TB] FAIL qsat%0d: got %b q=%0d expected %b q=%0d", i,
                         {bus1.IDLE, bus1.ENTER_P, bus1.EXIT_P, bus1.GLITCH_P}, bus1.QUIET_CNT, exp,
                         (i > 15) ? 15 : i);
            end
        end
        for (int k = 2; k <= 256; k++) begin
            bus1.B = 1'b1;
            tick();
            checks++;
            if ({bus1.IDLE, bus1.ENTER_P, bus1.EXIT_P, bus1.GLITCH_P} !== 4'b0010 || bus1.QUIET_CNT !== 4'd0) begin
                errors++;
                $display("[TB] FAIL esat_exit%0d: got %b q=%0d expected 0010 q=0", k,
                         {bus1.IDLE, bus1.ENTER_P, bus1.EXIT_P, bus1.GLITCH_P}, bus1.QUIET_CNT);
            end
            bus1.B = 1'b0;
            tick();
            checks++;
            if ({bus1.IDLE, bus1.ENTER_P, bus1.EXIT_P, bus1.GLITCH_P} !== 4'b1100
                || bus1.ENTRY_CNT !== 8'((k > 255) ? 255 : k)) begin
                errors++;
                $display("[TB] FAIL esat_enter%0d: got %b e=%0d expected 1100 e=%0d", k,
                         {bus1.IDLE, bus1.ENTER_P, bus1.EXIT_P, bus1.GLITCH_P}, bus1.ENTRY_CNT,
                         (k > 255) ? 255 : k);
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        bus0.EN = 1'b0;
        bus1.EN = 1'b0;
        {bus0.A, bus0.B, bus0.C, bus0.D} = 4'b0000;
        {bus1.A, bus1.B, bus1.C, bus1.D} = 4'b0000;
        test_reset();
        test_entry();
        test_glitch();
        test_wake();
        test_entry_aborted();
        test_freeze();
        test_reset_mid_run();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
